// File: rtl/vp_pixel_serializer.sv
// Character-row to pixel-beat serializer: a small FIFO of colour-index rows
// feeding a beat serializer with optional 2x horizontal pixel doubling.
module vp_pixel_serializer #(
    parameter int CHAR_WIDTH = 16,
    parameter int COLOR_BITS = 4,
    parameter int PIXELS_OUT = 4,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHAR_WIDTH*COLOR_BITS-1:0] i_pixels,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_hscale,
    input  logic                             i_flush,
    output logic [PIXELS_OUT*COLOR_BITS-1:0] o_pixels,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [$clog2(DEPTH):0]           o_level,
    output logic                             o_underrun
);

    localparam int WORD_W = CHAR_WIDTH * COLOR_BITS;
    localparam int BEAT_W = PIXELS_OUT * COLOR_BITS;
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int NBEATS = CHAR_WIDTH / PIXELS_OUT;
    localparam int BCW    = (2 * NBEATS > 1) ? $clog2(2 * NBEATS) : 1;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    logic [WORD_W-1:0] r_word;
    logic [BCW-1:0]    r_beat;
    logic              r_hs;
    logic              r_valid;
    logic [BEAT_W-1:0] r_pixels;
    logic              r_running;
    logic              r_underrun;

    logic              w_push;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [WORD_W-1:0] w_head;
    logic [BCW-1:0]    w_nextBeat;

    // Pixel p of a row sits MSB-first; in doubled mode each source pixel fills two output slots.
    function automatic logic [BEAT_W-1:0] beatPixels(input logic [WORD_W-1:0] word,
                                                    input logic [BCW-1:0]    beat,
                                                    input logic              hs);
        logic [BEAT_W-1:0] res;
        int                p;
        res = '0;
        for (int j = 0; j < PIXELS_OUT; j++) begin
            if (hs)
                p = int'(beat) * (PIXELS_OUT / 2) + j / 2;
            else
                p = int'(beat) * PIXELS_OUT + j;
            res[(PIXELS_OUT-1-j)*COLOR_BITS +: COLOR_BITS] =
                word[(CHAR_WIDTH-1-p)*COLOR_BITS +: COLOR_BITS];
        end
        return res;
    endfunction

    assign o_ready    = (r_count < CNT_W'(DEPTH));
    assign w_push     = i_valid && o_ready;
    assign w_accept   = r_valid && i_ready;
    assign w_last     = r_hs ? (r_beat == BCW'(2 * NBEATS - 1)) : (r_beat == BCW'(NBEATS - 1));
    assign w_load     = (r_count != '0) && (!r_valid || (w_accept && w_last));
    assign w_head     = r_mem[r_rdPtr];
    assign w_nextBeat = r_beat + BCW'(1);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush)
            r_mem[r_wrPtr] <= i_pixels;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + AW'(1);
            if (w_load)
                r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Reloading on the edge that accepts the last beat keeps words streaming back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_beat     <= '0;
            r_hs       <= 1'b0;
            r_valid    <= 1'b0;
            r_pixels   <= '0;
            r_running  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (i_flush) begin
            r_word     <= '0;
            r_beat     <= '0;
            r_hs       <= 1'b0;
            r_valid    <= 1'b0;
            r_pixels   <= '0;
            r_running  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= r_running && i_ready && !r_valid;
            if (w_accept)
                r_running <= 1'b1;
            if (w_load) begin
                r_word   <= w_head;
                r_hs     <= i_hscale;
                r_beat   <= '0;
                r_valid  <= 1'b1;
                r_pixels <= beatPixels(w_head, '0, i_hscale);
            end else if (w_accept) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_beat   <= w_nextBeat;
                    r_pixels <= beatPixels(r_word, w_nextBeat, r_hs);
                end
            end
        end
    end

    assign o_pixels   = r_pixels;
    assign o_valid    = r_valid;
    assign o_level    = r_count;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Directed self-checking bench for vp_pixel_serializer with default parameters.
module tb_vp_pixel_serializer;

    localparam int CHAR_WIDTH = 16;
    localparam int COLOR_BITS = 4;
    localparam int PIXELS_OUT = 4;
    localparam int DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] i_pixels;
    logic        i_valid;
    logic        o_ready;
    logic        i_hscale;
    logic        i_flush;
    logic [15:0] o_pixels;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_level;
    logic        o_underrun;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [63:0] BASE_WORD = 64'h0123_4567_89AB_CDEF;

    logic [15:0] expNormal [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] expDouble [8] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                   16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
    logic [63:0] words [5] = '{64'h1000_1001_1002_1003, 64'h2000_2001_2002_2003,
                               64'h3000_3001_3002_3003, 64'h4000_4001_4002_4003,
                               64'h5000_5001_5002_5003};

    vp_pixel_serializer #(
        .CHAR_WIDTH(CHAR_WIDTH),
        .COLOR_BITS(COLOR_BITS),
        .PIXELS_OUT(PIXELS_OUT),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pixels  (i_pixels),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_hscale  (i_hscale),
        .i_flush   (i_flush),
        .o_pixels  (o_pixels),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_level   (o_level),
        .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] pix, input logic hs,
                                 input logic rdy, input logic fl);
        i_valid  = valid;
        i_pixels = pix;
        i_hscale = hs;
        i_ready  = rdy;
        i_flush  = fl;
    endtask

    task automatic doFlush;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // One word at 1:1 from an idle, non-running state; leaves the design flushed.
    task automatic runBasic(input string tag);
        applyStimulus(1'b1, BASE_WORD, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, BASE_WORD, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, "_valid_after_push"}, 64'(o_valid), 64'd0);
        checkOutput({tag, "_level_after_push"}, 64'(o_level), 64'd1);
        tick();
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("%s_valid_b%0d", tag, b), 64'(o_valid), 64'd1);
            checkOutput($sformatf("%s_pix_b%0d", tag, b), 64'(o_pixels), 64'(expNormal[b]));
            checkOutput($sformatf("%s_undr_b%0d", tag, b), 64'(o_underrun), 64'd0);
            tick();
        end
        checkOutput({tag, "_valid_end"}, 64'(o_valid), 64'd0);
        checkOutput({tag, "_undr_end"}, 64'(o_underrun), 64'd0);
        i_ready = 1'b0;
        doFlush();
    endtask

    initial begin
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_pixels", 64'(o_pixels), 64'd0);
        checkOutput("rst_underrun", 64'(o_underrun), 64'd0);
        checkOutput("rst_level", 64'(o_level), 64'd0);
        checkOutput("rst_ready", 64'(o_ready), 64'd1);
        #11;
        rst_n = 1'b1;
        tick();

        runBasic("basic");

        // Doubled pixels; hscale toggled after the load must not affect this word
        applyStimulus(1'b1, BASE_WORD, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, BASE_WORD, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("dbl_valid_b0", 64'(o_valid), 64'd1);
        checkOutput("dbl_pix_b0", 64'(o_pixels), 64'(expDouble[0]));
        i_hscale = 1'b0;
        for (int b = 1; b < 8; b++) begin
            tick();
            checkOutput($sformatf("dbl_valid_b%0d", b), 64'(o_valid), 64'd1);
            checkOutput($sformatf("dbl_pix_b%0d", b), 64'(o_pixels), 64'(expDouble[b]));
        end
        tick();
        checkOutput("dbl_valid_end", 64'(o_valid), 64'd0);
        i_ready = 1'b0;
        doFlush();

        // Fill with backpressure, sixth word refused, then drain gap-free
        for (int w = 0; w < 5; w++) begin
            applyStimulus(1'b1, words[w], 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 64'h6000_6001_6002_6003, 1'b0, 1'b0, 1'b0);
        checkOutput("full_level", 64'(o_level), 64'd4);
        checkOutput("full_ready", 64'(o_ready), 64'd0);
        tick();
        checkOutput("full_level_after_refuse", 64'(o_level), 64'd4);
        checkOutput("full_ready_after_refuse", 64'(o_ready), 64'd0);
        checkOutput("full_held_valid", 64'(o_valid), 64'd1);
        checkOutput("full_held_pix", 64'(o_pixels), 64'h1000);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                checkOutput($sformatf("drain_valid_w%0d_b%0d", w, b), 64'(o_valid), 64'd1);
                checkOutput($sformatf("drain_pix_w%0d_b%0d", w, b), 64'(o_pixels),
                            64'(words[w][63-16*b -: 16]));
                tick();
            end
        end
        checkOutput("drain_valid_end", 64'(o_valid), 64'd0);
        checkOutput("drain_level_end", 64'(o_level), 64'd0);
        i_ready = 1'b0;
        doFlush();

        // Two words back to back, then starvation pulses until a new push arrives
        applyStimulus(1'b1, words[0], 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, words[1], 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("b2b_valid_%0d", k), 64'(o_valid), 64'd1);
            checkOutput($sformatf("b2b_pix_%0d", k), 64'(o_pixels),
                        64'(words[k/4][63-16*(k%4) -: 16]));
            tick();
        end
        checkOutput("b2b_valid_end", 64'(o_valid), 64'd0);
        checkOutput("b2b_undr_first_idle", 64'(o_underrun), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("b2b_undr_idle_%0d", k), 64'(o_underrun), 64'd1);
            checkOutput($sformatf("b2b_valid_idle_%0d", k), 64'(o_valid), 64'd0);
        end
        applyStimulus(1'b1, words[2], 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_undr_push", 64'(o_underrun), 64'd1);
        checkOutput("b2b_valid_push", 64'(o_valid), 64'd0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_valid_reload", 64'(o_valid), 64'd1);
        checkOutput("b2b_undr_reload", 64'(o_underrun), 64'd1);
        tick();
        checkOutput("b2b_undr_cleared", 64'(o_underrun), 64'd0);
        i_ready = 1'b0;
        doFlush();

        // Flush mid-word with a simultaneous push
        applyStimulus(1'b1, BASE_WORD, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, BASE_WORD, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("fl_pre_pix", 64'(o_pixels), 64'h4567);
        applyStimulus(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_level", 64'(o_level), 64'd0);
        checkOutput("fl_valid", 64'(o_valid), 64'd0);
        checkOutput("fl_ready", 64'(o_ready), 64'd1);
        checkOutput("fl_underrun", 64'(o_underrun), 64'd0);
        checkOutput("fl_pixels", 64'(o_pixels), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput($sformatf("fl_valid_after_%0d", k), 64'(o_valid), 64'd0);
            checkOutput($sformatf("fl_undr_after_%0d", k), 64'(o_underrun), 64'd0);
        end
        i_ready = 1'b0;
        doFlush();

        // Asynchronous reset between edges while holding data
        applyStimulus(1'b1, words[0], 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, words[1], 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("arst_pre_level", 64'(o_level), 64'd1);
        checkOutput("arst_pre_valid", 64'(o_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(o_valid), 64'd0);
        checkOutput("arst_level", 64'(o_level), 64'd0);
        checkOutput("arst_underrun", 64'(o_underrun), 64'd0);
        checkOutput("arst_ready", 64'(o_ready), 64'd1);
        checkOutput("arst_pixels", 64'(o_pixels), 64'd0);
        #2;
        rst_n = 1'b1;
        runBasic("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/vp_pixel_serializer.md
Name: vp_pixel_serializer

Overview:
- Parametrised successor to the bitmap-to-pixels output stage of the video pipeline.
- Accepts one full character row of colour indices per transfer and buffers it in a small FIFO.
- Emits PIXELS_OUT pixels per beat over a valid/ready handshake.
- Supports optional horizontal pixel doubling, flush and underrun detection, so the pipeline can be decoupled from the pixel-clock consumer.

Parameters:
- CHAR_WIDTH, 16: pixels per input character row.
- COLOR_BITS, 4: bits per pixel (colour index).
- PIXELS_OUT, 4: pixels per output beat. Must divide CHAR_WIDTH.
- DEPTH, 4: FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_pixels  in  CHAR_WIDTH*COLOR_BITS  character row; leftmost pixel in the MSBs.
- in_valid  in  1  in_pixels valid.
- in_ready  out  1  FIFO can accept a word.
- hscale  in  1  0 = 1:1, 1 = each pixel emitted twice. Sampled at word load.
- flush  in  1  synchronous clear of FIFO and serializer.
- out_pixels  out  PIXELS_OUT*COLOR_BITS  output beat; first pixel in the MSBs.
- out_valid  out  1  out_pixels valid.
- out_ready  in  1  consumer accepts beat.
- level  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the word in the serializer).
- underrun  out  1  one-cycle pulse on starvation.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0; serializer empty; running = 0.
  - Outputs: out_valid=0, out_pixels=0, underrun=0, level=0, in_ready=1.
- FIFO:
  - Push on rising edge when in_valid && in_ready.
  - in_ready = (count < DEPTH), from registered count only. When full, no push even if a pop occurs the same cycle.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
- Serializer:
  - Holds one word, beat index b and repeat phase r.
  - Beats per word: N = CHAR_WIDTH/PIXELS_OUT when hscale=0, 2N when hscale=1. The latched hscale applies to the whole word.
  - hscale=0: beat b carries pixels b*PIXELS_OUT .. b*PIXELS_OUT+PIXELS_OUT-1.
  - hscale=1: beat b carries pixels b*PIXELS_OUT/2 .. +PIXELS_OUT/2-1, each duplicated adjacently. PIXELS_OUT must be even when hscale is used.
- Output handshake:
  - out_valid is high while the serializer holds a word.
  - A beat advances only when out_valid && out_ready.
  - out_pixels is held stable while out_valid && !out_ready.
- Load:
  - The serializer loads from the FIFO head (pop) when it is empty, or on the same edge the last beat of the current word is accepted, if the FIFO is non-empty. This gives gap-free streaming.
  - Otherwise it becomes empty: out_valid drops the cycle after the last beat.
- Latency:
  - Word accepted on edge k into an empty FIFO and empty serializer → popped on edge k+1 → out_valid=1 with beat 0 after edge k+1.
  - A word pushed on edge k is never visible at out_valid before edge k+1; there is no push-to-output bypass.
- Underrun:
  - running is set on the first accepted beat and cleared by flush or reset.
  - underrun is registered: it pulses high for the cycle following any cycle where running && out_ready && !out_valid.
- Flush (synchronous, highest priority):
  - On the flush edge: count=0, pointers=0, serializer empty, running=0, out_valid=0.
  - A simultaneous push is discarded; a simultaneous out handshake is ignored.
  - in_ready is 1 the following cycle.
- out_pixels is a registered output. Its value is don't-care while out_valid=0, but it is cleared to 0 by reset and flush.

Test Plan:
- PIXELS_OUT=4, hscale=0, out_ready=1; push 64'h0123_4567_89AB_CDEF → beats 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF on consecutive cycles; out_valid first high 2 edges after push; underrun stays 0.
- Same word with hscale=1 → 8 beats: 16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF. Toggling hscale mid-word has no effect until the next load.
- out_ready=0; push 5 words with DEPTH=4 → first word moves to the serializer, level reaches 4, in_ready=0, word 6 is refused. Release out_ready → all words appear in order with no gap between the last beat of one word and beat 0 of the next.
- Back-to-back push of 2 words, then stop → after the 8th beat, out_valid=0; with out_ready held at 1, underrun pulses exactly once per idle cycle from the next cycle on, until a new push.
- Flush asserted mid-word with in_valid=1 the same cycle → next cycle: level=0, out_valid=0, in_ready=1, no underrun; the pushed word is not emitted.
- Drop reset asynchronously mid-stream (between edges) → out_valid, level and underrun go to 0 immediately. After release, a fresh push behaves as in the first scenario.
